uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- UART RX stage; the receive-side counterpart of the existing `transmitter`.
- Consumes a serial line (8N1 framing: start=0, DATA_WIDTH data bits LSB-first, one stop=1) and the shared 16x oversample `tick` from `baudrate_generator`.
- Outputs a parallel byte with a one-clock valid strobe and a framing-error strobe.
- Sits directly downstream of `transmitter` in loopback benches and at the chip RX pin in the top level.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- OVERSAMPLE, 16, ticks per bit period; even, >=4.

Ports:
- clk  input  1  system clock, 50 MHz nominal; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- tick  input  1  one-clk pulse from baudrate_generator, OVERSAMPLE pulses per bit.
- rx_in  input  1  asynchronous serial line, idle high.
- rx_out  output  DATA_WIDTH  last correctly received word.
- rx_dv  output  1  one-clk pulse when rx_out is updated.
- rx_frame_err  output  1  one-clk pulse when the stop bit samples 0.
- rx_busy  output  1  high whenever the state is not IDLE.

Behaviour:

Interface:
- One clock, `clk`; reset `rst` is synchronous and active-high.
- rst=1 at a clk edge sets: state=IDLE, rx_out=0, rx_dv=0, rx_frame_err=0, rx_busy=0, sync flops=1, tick_cnt=0, bit_idx=0, shift register=0.
- rst has priority over all other events, including mid-frame; the partial frame is discarded with no strobe.

Synchronizer:
- 2-flop synchronizer on rx_in; rx_sync is the output of the 2nd flop.
- All decisions use rx_sync only.

Counters:
- tick_cnt: width ceil(log2(OVERSAMPLE)); advances only on cycles where tick=1.
- bit_idx: 0..DATA_WIDTH-1.

State machine:
- IDLE: rx_sync==0 -> START, tick_cnt=0. No tick is required to leave IDLE.
- START: on tick, tick_cnt++. On the tick where tick_cnt==OVERSAMPLE/2-1 (mid start bit):
  - rx_sync==0 -> DATA, tick_cnt=0, bit_idx=0.
  - rx_sync==1 -> IDLE (glitch rejected, no strobes).
- DATA: on tick with tick_cnt==OVERSAMPLE-1, i.e. mid-bit:
  - shift reg <= {rx_sync, shift[DATA_WIDTH-1:1]} (LSB-first); tick_cnt=0.
  - If bit_idx==DATA_WIDTH-1 -> STOP, else bit_idx++.
  - Other ticks: tick_cnt++.
- STOP: on tick with tick_cnt==OVERSAMPLE-1:
  - rx_sync==1: rx_out<=shift reg, rx_dv=1 for the next clk only -> IDLE.
  - rx_sync==0: rx_frame_err=1 for one clk, rx_out unchanged, rx_dv stays 0 -> BREAK.
- BREAK: wait until rx_sync==1, then -> IDLE. This prevents a held-low line from producing repeated errors.

Timing and edge cases:
- rx_dv and rx_frame_err are registered and never both high.
- rx_dv rises about (DATA_WIDTH+1.5) bit times after the start falling edge, plus 2-3 clk of sync latency.
- A new start edge is accepted in IDLE on the clk right after the strobe, so back-to-back frames with zero idle gap are received.
- rx_out holds its value until the next valid frame.
- tick and state transitions coinciding: a transition consumes that tick; no double counting.

Test Plan:
- Loopback with `transmitter`, tx_in=0xA5 -> exactly one rx_dv pulse; rx_out=0xA5; rx_frame_err never 1; rx_dv about 82.5 us after tx_out falls (±1 tick + 3 clk).
- Send 0xF0 then 0x3C back-to-back, stop bit followed immediately by the next start -> two rx_dv pulses, rx_out=0xF0 then 0x3C; rx_busy low for at most 1 bit time between frames.
- Glitch: rx_in low for 3 ticks, then high -> returns to IDLE; no rx_dv, no rx_frame_err; rx_out unchanged.
- Framing error: drive 0x3C with stop bit=0, then line high -> one rx_frame_err pulse, no rx_dv, rx_out keeps previous value. A following 0x5A frame is received correctly.
- Break: hold rx_in low for 20 bit times -> exactly one rx_frame_err; no further strobes; after the line returns high, a 0xC3 frame is received.
- Reset mid-frame: assert rst for 1 clk during data bit 4 of 0xA5 -> next clk rx_busy=0, rx_out=0, no strobes. A subsequent 0x81 frame produces rx_out=0x81 with one rx_dv.

Source files
------------

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop input synchronizer feeding an oversampled
// mid-bit sampling FSM with data-valid and framing-error strobes.
`timescale 1ns/1ps
module uart_receiver #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  rx_in,
  output logic [DATA_WIDTH-1:0] rx_out,
  output logic                  rx_dv,
  output logic                  rx_frame_err,
  output logic                  rx_busy
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t                state_reg;
  logic [1:0]            sync_reg;
  logic [TW-1:0]         tick_cnt_reg;
  logic [BW-1:0]         bit_idx_reg;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] rx_out_reg;
  logic                  rx_dv_reg;
  logic                  rx_frame_err_reg;
  logic                  rx_busy_reg;
  logic                  rx_sync;

  // Idle-high reset value keeps a reset from looking like a start edge.
  always_ff @(posedge clk) begin
    if (rst) sync_reg <= 2'b11;
    else     sync_reg <= {sync_reg[0], rx_in};
  end
  assign rx_sync = sync_reg[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      tick_cnt_reg     <= '0;
      bit_idx_reg      <= '0;
      shift_reg        <= '0;
      rx_out_reg       <= '0;
      rx_dv_reg        <= 1'b0;
      rx_frame_err_reg <= 1'b0;
      rx_busy_reg      <= 1'b0;
    end else begin
      rx_dv_reg        <= 1'b0;
      rx_frame_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!rx_sync) begin
            state_reg    <= START;
            tick_cnt_reg <= '0;
            rx_busy_reg  <= 1'b1;
          end
        end
        START: begin
          // Half a bit in: a still-low line is a real start bit, else a glitch.
          if (tick) begin
            if (tick_cnt_reg == HALF_LAST) begin
              tick_cnt_reg <= '0;
              if (!rx_sync) begin
                state_reg   <= DATA;
                bit_idx_reg <= '0;
              end else begin
                state_reg   <= IDLE;
                rx_busy_reg <= 1'b0;
              end
            end else begin
              tick_cnt_reg <= tick_cnt_reg + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (tick_cnt_reg == FULL_LAST) begin
              tick_cnt_reg <= '0;
              shift_reg    <= {rx_sync, shift_reg[DATA_WIDTH-1:1]};
              if (bit_idx_reg == BIT_LAST) state_reg <= STOP;
              else                         bit_idx_reg <= bit_idx_reg + 1'b1;
            end else begin
              tick_cnt_reg <= tick_cnt_reg + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (tick_cnt_reg == FULL_LAST) begin
              tick_cnt_reg <= '0;
              if (rx_sync) begin
                rx_out_reg  <= shift_reg;
                rx_dv_reg   <= 1'b1;
                state_reg   <= IDLE;
                rx_busy_reg <= 1'b0;
              end else begin
                rx_frame_err_reg <= 1'b1;
                state_reg        <= BRK;
              end
            end else begin
              tick_cnt_reg <= tick_cnt_reg + 1'b1;
            end
          end
        end
        BRK: begin
          // Hold here while the line stays low so a break reports only once.
          if (rx_sync) begin
            state_reg   <= IDLE;
            rx_busy_reg <= 1'b0;
          end
        end
        default: begin
          state_reg   <= IDLE;
          rx_busy_reg <= 1'b0;
        end
      endcase
    end
  end

  assign rx_out       = rx_out_reg;
  assign rx_dv        = rx_dv_reg;
  assign rx_frame_err = rx_frame_err_reg;
  assign rx_busy      = rx_busy_reg;
endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: frames are serialised by tasks, the
// expected strobe is queued before each frame and checked as strobes appear.
`timescale 1ns/1ps
module tb_uart_receiver;
  localparam int DW       = 8;
  localparam int OS       = 16;
  localparam int TDIV     = 4;
  localparam int BIT_CLKS = OS * TDIV;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick = 1'b0;
  logic          rx_in = 1'b1;
  logic [DW-1:0] rx_out;
  logic          rx_dv;
  logic          rx_frame_err;
  logic          rx_busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int tick_div = 0;
  int dv_cyc = 0;
  int fall_cyc = 0;
  int n_dv = 0;
  int n_err = 0;
  logic [8:0] sb_q[$];  // {is_frame_err, expected rx_out}

  uart_receiver #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
    .clk(clk), .rst(rst), .tick(tick), .rx_in(rx_in),
    .rx_out(rx_out), .rx_dv(rx_dv), .rx_frame_err(rx_frame_err), .rx_busy(rx_busy)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    tick_div <= (tick_div == TDIV - 1) ? 0 : tick_div + 1;
    tick     <= (tick_div == TDIV - 1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst && (rx_dv || rx_frame_err)) begin
      $display("txn cyc=%0d dv=%0b frame_err=%0b rx_out=0x%02h", cyc, rx_dv, rx_frame_err, rx_out);
      check("dv_err_exclusive", {31'd0, rx_dv & rx_frame_err}, 32'd0);
      check("sb_nonempty", {31'd0, sb_q.size() != 0}, 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("strobe_kind", {31'd0, rx_frame_err}, {31'd0, e[8]});
        check("rx_out", {24'd0, rx_out}, {24'd0, e[7:0]});
      end
      if (rx_dv) begin
        n_dv++;
        dv_cyc = cyc;
      end
      if (rx_frame_err) n_err++;
    end
  end

  task automatic send_bits(input logic [9:0] fr, input int nb);
    for (int i = 0; i < nb; i++) begin
      rx_in = fr[i];
      repeat (BIT_CLKS) @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic stop);
    send_bits({stop, d, 1'b0}, 10);
  endtask

  task automatic idle(input int nbits);
    rx_in = 1'b1;
    repeat (nbits * BIT_CLKS) @(posedge clk);
    #1;
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    repeat (5) @(posedge clk);
    #1;
    check("reset_rx_out", {24'd0, rx_out}, 32'd0);
    check("reset_dv", {31'd0, rx_dv}, 32'd0);
    check("reset_err", {31'd0, rx_frame_err}, 32'd0);
    check("reset_busy", {31'd0, rx_busy}, 32'd0);
    rst = 1'b0;
    idle(2);

    // Single frame and latency from the start edge.
    sb_q.push_back({1'b0, 8'hA5});
    fall_cyc = cyc;
    send(8'hA5, 1'b1);
    idle(1);
    lat = dv_cyc - fall_cyc;
    check("a5_latency_ok", {31'd0, (lat >= 600) && (lat <= 620)}, 32'd1);
    check("a5_dv_count", n_dv, 1);

    // Back-to-back frames with no idle gap.
    sb_q.push_back({1'b0, 8'hF0});
    sb_q.push_back({1'b0, 8'h3C});
    send(8'hF0, 1'b1);
    send(8'h3C, 1'b1);
    idle(2);
    check("b2b_dv_count", n_dv, 3);

    // Three-tick glitch must be rejected silently.
    rx_in = 1'b0;
    repeat (3 * TDIV) @(posedge clk);
    #1;
    idle(2);
    check("glitch_busy", {31'd0, rx_busy}, 32'd0);
    check("glitch_rx_out", {24'd0, rx_out}, 32'h3C);

    // Framing error keeps previous word, then a good frame.
    sb_q.push_back({1'b1, 8'h3C});
    send(8'h3C, 1'b0);
    idle(2);
    check("ferr_busy", {31'd0, rx_busy}, 32'd0);
    sb_q.push_back({1'b0, 8'h5A});
    send(8'h5A, 1'b1);
    idle(2);

    // Break: 20 bit times low produces exactly one error.
    sb_q.push_back({1'b1, 8'h5A});
    rx_in = 1'b0;
    repeat (20 * BIT_CLKS) @(posedge clk);
    #1;
    check("break_err_count", n_err, 2);
    check("break_busy_held", {31'd0, rx_busy}, 32'd1);
    idle(2);
    sb_q.push_back({1'b0, 8'hC3});
    send(8'hC3, 1'b1);
    idle(2);

    // Reset during data bit 4 discards the partial frame.
    send_bits({1'b1, 8'hA5, 1'b0}, 5);
    repeat (BIT_CLKS / 2) @(posedge clk);
    #1;
    rx_in = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_busy", {31'd0, rx_busy}, 32'd0);
    check("rst_rx_out", {24'd0, rx_out}, 32'd0);
    idle(2);
    sb_q.push_back({1'b0, 8'h81});
    send(8'h81, 1'b1);
    idle(2);

    for (int i = 0; i < 2000 && sb_q.size() != 0; i++) @(posedge clk);
    #1;
    check("sb_empty", sb_q.size(), 0);
    check("total_dv", n_dv, 6);
    check("total_err", n_err, 2);
    check("final_rx_out", {24'd0, rx_out}, 32'h81);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
